pixel_writer: RTL and testbench
===============================

PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 128: number of addressable pixels downstream.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: request buffer entries, power of two, at least 2.
REQ-003 SHALL have parameter STROBE_CYCLES, default 4: clk cycles per strobe phase, at least 1.
REQ-004 SHALL have port clk  input  1  single clock for all logic, about 25 MHz.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted this cycle when in_valid=1.
REQ-008 SHALL have port in_fill  input  1  1 = write in_color to every address 0..NUM_LEDS-1 (in_addr ignored).
REQ-009 SHALL have port in_addr  input  16  target pixel for a single write.
REQ-010 SHALL have port in_color  input  24  GRB/RGB word, passed through unmodified.
REQ-011 SHALL have port address  output  16  pixel address to the neopixel driver.
REQ-012 SHALL have port color  output  24  pixel colour to the neopixel driver.
REQ-013 SHALL have port color_clock  output  1  write strobe; the driver latches address/color on its rising edge.
REQ-014 SHALL have port busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-015 SHALL have port err_addr  output  1  one-cycle pulse when a single write with in_addr >= NUM_LEDS is dropped.

Function
REQ-016 SHALL accept a request on any rising clk edge where in_valid=1 and in_ready=1, storing {in_fill, in_addr, in_color} in the FIFO.
REQ-017 SHALL drive in_ready=1 exactly when the FIFO is not full; in_ready SHALL NOT depend combinationally on in_valid.
REQ-018 SHALL allow push and pop in the same cycle, including when the FIFO is full; the count is unchanged in that case.
REQ-019 SHALL implement the FSM states IDLE, SETUP, STROBE and NEXT.
REQ-020 IDLE: when the FIFO is non-empty, SHALL pop the head entry, load address/color and enter SETUP on the same edge.
REQ-021 SETUP: SHALL hold color_clock=0 and keep address/color stable for STROBE_CYCLES cycles, then enter STROBE.
REQ-022 STROBE: SHALL hold color_clock=1 and keep address/color stable for STROBE_CYCLES cycles, then enter NEXT.
REQ-023 NEXT (1 cycle, color_clock=0), fill in progress with address < NUM_LEDS-1: SHALL increment address and enter SETUP.
REQ-024 NEXT, otherwise: SHALL pop the next entry into SETUP if the FIFO is non-empty, or enter IDLE if it is empty.
REQ-025 SHALL complete a single write in 2*STROBE_CYCLES+1 cycles, and a fill in NUM_LEDS*(2*STROBE_CYCLES+1) cycles.
REQ-026 Single write with in_addr >= NUM_LEDS: SHALL be popped and discarded with no color_clock edge, err_addr pulsed for 1 cycle, and the FSM staying in or returning to IDLE.
REQ-027 SHALL compute address arithmetic in 16 bits; a fill SHALL stop at NUM_LEDS-1 and never wrap.
REQ-028 SHALL NOT abort an active fill or write when new requests arrive; requests queue behind it.
REQ-029 color and address SHALL hold their last values while IDLE.

Reset
REQ-030 While rst_n=0, SHALL force address=0, color=0, color_clock=0, err_addr=0, busy=0 and the FSM to IDLE, and SHALL empty the FIFO.
REQ-031 During reset, in_ready SHALL be 0; it SHALL be 1 from the first clk edge after rst_n rises.
REQ-032 Reset asserted mid-strobe SHALL drop color_clock to 0 immediately (asynchronously) and discard the in-flight request.

Structure
REQ-033 The FSM state encoding and the FIFO entry layout {fill, addr[15:0], color[23:0]} (41 bits) SHALL live in a shared package.
REQ-034 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by width and depth; the FSM and strobe counter live in pixel_writer.

Verification
REQ-035 Single write: in_addr=5, in_color=0x100000, STROBE_CYCLES=4 -> one color_clock rise with address=5 and color=0x100000; busy drops 9 cycles after the pop.
REQ-036 Fill: NUM_LEDS=8, in_color=0x001010 -> exactly 8 rising edges at addresses 0..7, all with color=0x001010, then IDLE.
REQ-037 Back-pressure: push 6 requests without gaps into a FIFO with FIFO_DEPTH=4 -> in_ready low while full, no request lost, edges occur in push order.
REQ-038 Bad address: in_addr=128 with NUM_LEDS=128 -> err_addr pulses once, no color_clock edge, and the next request is processed normally.
REQ-039 Reset during STROBE of a fill -> color_clock=0 immediately, busy=0, and address=0 on release.
REQ-040 Push and pop in the same cycle with the FIFO full -> count stays at 4 and the entry order is preserved.

Source files
------------

// File: rtl/pixel_writer_pkg.sv
// Shared types for the pixel writer: FSM state encoding and the request word
// stored in the FIFO.
package pixel_writer_pkg;

    localparam int ADDR_W  = 16;
    localparam int COLOR_W = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        NEXT   = 2'd3
    } state_t;

    typedef struct packed {
        logic               fill;
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } req_t;

    localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-two depth. A push into a full FIFO is taken
// when a pop happens in the same cycle, so the count stays unchanged.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      count;
    logic             do_push, do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pixel_writer.sv
// Queues pixel write/fill requests and replays them to a neopixel driver as
// address/color with a slow setup/strobe handshake on color_clock.
import pixel_writer_pkg::*;

module pixel_writer #(
    parameter int NUM_LEDS      = 128,
    parameter int FIFO_DEPTH    = 4,
    parameter int STROBE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_fill,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic [COLOR_W-1:0] in_color,
    output logic [ADDR_W-1:0]  address,
    output logic [COLOR_W-1:0] color,
    output logic               color_clock,
    output logic               busy,
    output logic               err_addr
);
    localparam int               CNT_W     = $clog2(STROBE_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LEDS - 1);

    state_t            state, state_nxt;
    req_t              wr_req, head;
    logic              fifo_full, fifo_empty, push, pop;
    logic              ready_en, fill_q, load, step, drop;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_done, head_bad, fill_more;

    assign wr_req   = '{fill: in_fill, addr: in_addr, color: in_color};
    // ready_en keeps in_ready low until the first edge after reset release
    assign in_ready = ready_en && !fifo_full;
    assign push     = in_valid && in_ready;

    sync_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (wr_req),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cnt_done  = (cnt == CNT_W'(STROBE_CYCLES - 1));
    assign head_bad  = !head.fill && (head.addr > LAST_ADDR);
    assign fill_more = fill_q && (address < LAST_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: if (!fifo_empty) begin
                pop = 1'b1;
                if (head_bad) drop = 1'b1;
                else begin
                    load      = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP:  if (cnt_done) state_nxt = STROBE;
            STROBE: if (cnt_done) state_nxt = NEXT;
            NEXT: begin
                if (fill_more) begin
                    step      = 1'b1;
                    state_nxt = SETUP;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_bad) begin
                        drop      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        load      = 1'b1;
                        state_nxt = SETUP;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        color_clock = (state == STROBE);
        busy        = !fifo_empty || (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
            cnt      <= '0;
            address  <= '0;
            color    <= '0;
            fill_q   <= 1'b0;
            err_addr <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            err_addr <= drop;
            if ((state == SETUP || state == STROBE) && !cnt_done) cnt <= cnt + 1'b1;
            else                                                  cnt <= '0;
            if (load) begin
                address <= head.fill ? '0 : head.addr;
                color   <= head.color;
                fill_q  <= head.fill;
            end else if (step) begin
                address <= address + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench: expected (address,color) strobes are queued as requests are
// accepted and compared on every color_clock rise.
module tb_pixel_writer;
    localparam int NL = 8, FD = 4, SC = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_fill = 1'b0;
    logic [15:0] in_addr = '0;
    logic [23:0] in_color = '0;
    logic        in_ready, color_clock, busy, err_addr;
    logic [15:0] address;
    logic [23:0] color;

    pixel_writer #(.NUM_LEDS(NL), .FIFO_DEPTH(FD), .STROBE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_fill(in_fill), .in_addr(in_addr), .in_color(in_color),
        .address(address), .color(color), .color_clock(color_clock),
        .busy(busy), .err_addr(err_addr)
    );

    always #20 clk = ~clk;

    int          n_chk = 0, n_fail = 0;
    int          edges = 0, errs = 0, exp_errs = 0, blocked = 0;
    logic [39:0] exp_q[$];
    logic [39:0] e;
    logic        prev_cc = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (color_clock && !prev_cc) begin
                edges++;
                if (exp_q.size() == 0) chk("unexpected_edge", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("edge_addr", address, e[39:24]);
                    chk("edge_color", color, e[23:0]);
                end
            end
            if (err_addr) errs++;
            prev_cc = color_clock;
        end else begin
            prev_cc = 1'b0;
        end
    end

    task automatic send(input logic f, input logic [15:0] a, input logic [23:0] c);
        int guard = 0;
        in_valid = 1'b1; in_fill = f; in_addr = a; in_color = c;
        while (!in_ready && guard < 500) begin
            blocked++;
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        else if (f) for (int i = 0; i < NL; i++) exp_q.push_back({16'(i), c});
        else if (a < NL) exp_q.push_back({a, c});
        else exp_errs++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (busy && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) chk({tag, "_timeout"}, 0, 1);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        int n, g, e0;
        // reset state
        #5;
        chk("rst_address", address, 0);
        chk("rst_color", color, 0);
        chk("rst_cc", color_clock, 0);
        chk("rst_err", err_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("ready_before_edge", in_ready, 0);
        @(negedge clk);
        chk("ready_after_edge", in_ready, 1);

        // single write: 1 queue cycle + 2*SC+1 FSM cycles of busy
        send(1'b0, 16'd5, 24'h100000);
        n = 0;
        while (busy && n < 100) begin n++; @(negedge clk); end
        chk("single_busy_cycles", n, 2*SC + 2);
        chk("single_pending", exp_q.size(), 0);
        chk("idle_hold_addr", address, 5);
        chk("idle_hold_color", color, 24'h100000);
        chk("idle_cc_low", color_clock, 0);

        // fill covers every address and stops at the last one
        e0 = edges;
        send(1'b1, 16'd0, 24'h001010);
        wait_idle("fill");
        chk("fill_edges", edges - e0, NL);
        chk("fill_last_addr", address, NL - 1);

        // fill ignores in_addr even when it is out of range
        e0 = edges;
        send(1'b1, 16'hFFFF, 24'h0A0B0C);
        wait_idle("fill_badaddr");
        chk("fill_badaddr_edges", edges - e0, NL);

        // back-pressure: 6 gapless pushes into a 4-deep FIFO
        blocked = 0;
        send(1'b0, 16'd1, 24'h000001);
        send(1'b0, 16'd3, 24'h000003);
        send(1'b0, 16'd0, 24'h000010);
        send(1'b0, 16'd7, 24'h000007);
        send(1'b0, 16'd2, 24'h000002);
        send(1'b0, 16'd6, 24'h000006);
        chk("bp_saw_not_ready", blocked > 0, 1);
        wait_idle("bp");

        // bad addresses popped from IDLE and from NEXT
        e0 = edges;
        send(1'b0, NL[15:0], 24'hDEAD00);
        repeat (3) @(negedge clk);
        send(1'b0, 16'd4, 24'h040404);
        send(1'b0, 16'd128, 24'h111111);
        send(1'b0, 16'hFFFF, 24'h222222);
        send(1'b0, 16'd6, 24'h060606);
        wait_idle("bad");
        chk("bad_edges", edges - e0, 2);
        chk("bad_err_count", errs, exp_errs);

        // reset during a strobe of a fill
        send(1'b1, 16'd0, 24'hABCDEF);
        g = 0;
        while (!(color_clock && address == 16'd2) && g < 500) begin @(negedge clk); g++; end
        chk("mid_strobe_reached", color_clock, 1);
        #7 rst_n = 1'b0;
        #1;
        chk("arst_cc", color_clock, 0);
        chk("arst_busy", busy, 0);
        chk("arst_addr", address, 0);
        chk("arst_ready", in_ready, 0);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_addr", address, 0);
        chk("post_rst_busy", busy, 0);
        send(1'b0, 16'd3, 24'h0F0F0F);
        wait_idle("post_rst");
        chk("final_err_count", errs, exp_errs);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
